// File: rtl/pending_encoder_4to2.sv
// -----------------------------------------------------------------------------
// pending_encoder_4to2
//
// Purpose:
//    N-line request encoder. One-cycle request pulses on D are collected in a
//    pending register. The index of the highest-numbered pending line is
//    offered on Y with a valid/ready handshake. The offered line is cleared
//    when the consumer accepts it.
//
// Parameters:
//    N     number of request lines (default 4)
//    IDXW  index width, 2**IDXW >= N (default 2)
//
// Ports:
//    clk    in   1     rising-edge clock
//    rst    in   1     synchronous active-high reset
//    E      in   1     capture enable (D ignored when 0)
//    D      in   N     request pulses, bit i requests line i
//    RDY    in   1     consumer ready
//    Y      out  IDXW  offered index (registered)
//    V      out  1     Y valid (registered)
//    PEND   out  N     pending register
//    OVF    out  1     sticky overflow: request hit an already-pending line
//    DROPS  out  8     saturating count of absorbed duplicate requests
//                      (present only when PENDING_ENC_DROP_CNT_EN is defined)
//
// Optional feature macro: PENDING_ENC_DROP_CNT_EN
// -----------------------------------------------------------------------------
module pending_encoder_4to2 #(
   parameter int N    = 4,
   parameter int IDXW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            E,
   input  logic [N-1:0]    D,
   input  logic            RDY,
   output logic [IDXW-1:0] Y,
   output logic            V,
   output logic [N-1:0]    PEND,
   output logic            OVF
`ifdef PENDING_ENC_DROP_CNT_EN
   ,
   output logic [7:0]      DROPS
`endif
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [N-1:0]    r_pend;
   logic [N-1:0]    w_pend_next;
   logic [N-1:0]    w_set;
   logic [N-1:0]    w_clr;
   logic [N-1:0]    w_ovf_vec;
   logic [IDXW-1:0] r_y;
   logic [IDXW-1:0] w_y_next;
   logic            r_v;
   logic            w_v_next;
   logic            r_ovf;
   logic            w_ovf_next;

   // Index of the most significant set bit; 0 when nothing is set.
   function automatic logic [IDXW-1:0] prio(input logic [N-1:0] x);
      logic [IDXW-1:0] idx;
      idx = {IDXW{1'b0}};
      for (int i = 0; i < N; i++) begin
         idx = x[i] ? IDXW'(i) : idx;
      end
      return idx;
   endfunction

   // One-hot expansion of an index into an N-bit line mask.
   function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] idx);
      logic [N-1:0] oh;
      for (int i = 0; i < N; i++) begin
         oh[i] = (idx == IDXW'(i));
      end
      return oh;
   endfunction

   // Capture, handshake clear and overflow detection.
   always_comb begin
      w_set = D & {N{E}};
      if (r_v && RDY) begin
         w_clr = onehot(r_y);
      end else begin
         w_clr = {N{1'b0}};
      end
      // A set on the same cycle as its clear re-arms the line: set wins.
      w_pend_next = (r_pend & ~w_clr) | w_set;
      // Only a set onto a line that stays pending is a lost duplicate.
      w_ovf_vec   = w_set & r_pend & ~w_clr;
      w_ovf_next  = r_ovf | (|w_ovf_vec);
   end

   // Next-state and next-offer logic.
   always_comb begin
      w_state_next = r_state;
      w_y_next     = r_y;
      w_v_next     = r_v;
      case (r_state)
         ST_IDLE: begin
            if (w_pend_next != {N{1'b0}}) begin
               w_state_next = ST_OFFER;
               w_y_next     = prio(w_pend_next);
               w_v_next     = 1'b1;
            end else begin
               w_state_next = ST_IDLE;
               w_v_next     = 1'b0;
            end
         end
         ST_OFFER: begin
            if (!RDY) begin
               // Offer is frozen under backpressure, even against a
               // newly arrived higher-priority line.
               w_state_next = ST_OFFER;
               w_v_next     = 1'b1;
            end else if (w_pend_next != {N{1'b0}}) begin
               w_state_next = ST_OFFER;
               w_y_next     = prio(w_pend_next);
               w_v_next     = 1'b1;
            end else begin
               w_state_next = ST_IDLE;
               w_v_next     = 1'b0;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_v_next     = 1'b0;
         end
      endcase
   end

   // State, offer, pending and overflow registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_pend  <= {N{1'b0}};
         r_y     <= {IDXW{1'b0}};
         r_v     <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_pend  <= w_pend_next;
         r_y     <= w_y_next;
         r_v     <= w_v_next;
         r_ovf   <= w_ovf_next;
      end
   end

   assign Y    = r_y;
   assign V    = r_v;
   assign PEND = r_pend;
   assign OVF  = r_ovf;

`ifdef PENDING_ENC_DROP_CNT_EN
   logic [7:0]  r_drops;
   logic [7:0]  w_drops_next;
   logic [16:0] w_drops_sum;

   // Number of set bits in a line mask.
   function automatic logic [15:0] popcount(input logic [N-1:0] x);
      logic [15:0] cnt;
      cnt = 16'd0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + {15'd0, x[i]};
      end
      return cnt;
   endfunction

   // Saturating accumulation of absorbed duplicates.
   always_comb begin
      w_drops_sum = {9'd0, r_drops} + {1'b0, popcount(w_ovf_vec)};
      if (w_drops_sum > 17'd255) begin
         w_drops_next = 8'd255;
      end else begin
         w_drops_next = w_drops_sum[7:0];
      end
   end

   // Drop counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drops <= 8'd0;
      end else begin
         r_drops <= w_drops_next;
      end
   end

   assign DROPS = r_drops;
`endif

endmodule

// File: tb/tb_pending_encoder_4to2.sv
module tb_pending_encoder_4to2;

   logic       clk;
   logic       rst;
   logic       E;
   logic [3:0] D;
   logic       RDY;
   logic [1:0] Y;
   logic       V;
   logic [3:0] PEND;
   logic       OVF;
`ifdef PENDING_ENC_DROP_CNT_EN
   logic [7:0] DROPS;
`endif

   int errors = 0;
   int checks = 0;

   pending_encoder_4to2 #(.N(4), .IDXW(2)) dut (
      .clk  (clk),
      .rst  (rst),
      .E    (E),
      .D    (D),
      .RDY  (RDY),
      .Y    (Y),
      .V    (V),
      .PEND (PEND),
      .OVF  (OVF)
`ifdef PENDING_ENC_DROP_CNT_EN
      ,
      .DROPS(DROPS)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       e;
      logic [3:0] d;
      logic       rdy;
      logic [1:0] y;
      logic       v;
      logic [3:0] pend;
      logic       ovf;
      logic [7:0] drops;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present inputs for one cycle; outputs are stable 1 time unit after the edge.
   task automatic step(input logic r, input logic e, input logic [3:0] d, input logic rdy);
      rst = r;
      E   = e;
      D   = d;
      RDY = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [1:0] y, input logic v,
                             input logic [3:0] pend, input logic ovf);
      check({tag, ".Y"},    {6'd0, Y},    {6'd0, y});
      check({tag, ".V"},    {7'd0, V},    {7'd0, v});
      check({tag, ".PEND"}, {4'd0, PEND}, {4'd0, pend});
      check({tag, ".OVF"},  {7'd0, OVF},  {7'd0, ovf});
   endtask

   initial begin
      rst = 1'b1;
      E   = 1'b0;
      D   = 4'b0000;
      RDY = 1'b0;

      //               rst   e     d        rdy  |  y      v     pend     ovf   drops
      vecs.push_back('{1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 8'd0}); // reset
      vecs.push_back('{1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 8'd0});
      vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 8'd0}); // idle
      vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 8'd0}); // RDY ignored
      vecs.push_back('{1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 8'd0}); // single
      vecs.push_back('{1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 8'd0}); // accepted, Y holds
      vecs.push_back('{1'b0, 1'b1, 4'b1011, 1'b1, 2'd3, 1'b1, 4'b1011, 1'b0, 8'd0}); // priority
      vecs.push_back('{1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0011, 1'b0, 8'd0});
      vecs.push_back('{1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0, 8'd0});
      vecs.push_back('{1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 8'd0}); // drained
      vecs.push_back('{1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0, 8'd0}); // backpressure
      vecs.push_back('{1'b0, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b1, 4'b1001, 1'b0, 8'd0}); // Y frozen
      vecs.push_back('{1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b1001, 1'b0, 8'd0});
      vecs.push_back('{1'b0, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b0, 8'd0}); // 0 accepted
      vecs.push_back('{1'b0, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0, 8'd0});
      vecs.push_back('{1'b0, 1'b0, 4'b0100, 1'b0, 2'd3, 1'b0, 4'b0000, 1'b0, 8'd0}); // E=0 gate
      vecs.push_back('{1'b0, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0, 8'd0});
      vecs.push_back('{1'b0, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b1, 8'd1}); // overflow
      vecs.push_back('{1'b0, 1'b0, 4'b1000, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b1, 8'd1}); // E=0 still drains
      vecs.push_back('{1'b1, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 8'd0}); // reset wins
      vecs.push_back('{1'b0, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0, 8'd0});
      vecs.push_back('{1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 8'd0}); // collision
      vecs.push_back('{1'b0, 1'b1, 4'b0110, 1'b1, 2'd2, 1'b1, 4'b0110, 1'b0, 8'd0}); // collision + new
      vecs.push_back('{1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 8'd0}); // mid-offer reset
      vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 8'd0});

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].e, vecs[i].d, vecs[i].rdy);
         check_outs($sformatf("vec%0d", i), vecs[i].y, vecs[i].v, vecs[i].pend, vecs[i].ovf);
`ifdef PENDING_ENC_DROP_CNT_EN
         check($sformatf("vec%0d.DROPS", i), DROPS, vecs[i].drops);
`endif
      end

      // Back-to-back drain: one index per cycle with RDY held high.
      step(1'b0, 1'b1, 4'b1111, 1'b1);
      check_outs("b2b0", 2'd3, 1'b1, 4'b1111, 1'b0);
      step(1'b0, 1'b1, 4'b0000, 1'b1);
      check_outs("b2b1", 2'd2, 1'b1, 4'b0111, 1'b0);
      step(1'b0, 1'b1, 4'b0000, 1'b1);
      check_outs("b2b2", 2'd1, 1'b1, 4'b0011, 1'b0);
      step(1'b0, 1'b1, 4'b0000, 1'b1);
      check_outs("b2b3", 2'd0, 1'b1, 4'b0001, 1'b0);
      begin
         int n;
         n = 0;
         while (V !== 1'b0 && n < 8) begin
            step(1'b0, 1'b1, 4'b0000, 1'b1);
            n++;
         end
         check("b2b_drain_cycles", 8'(n), 8'd1);
      end

      // Acceptance and a new higher request in the same cycle.
      step(1'b0, 1'b1, 4'b0001, 1'b0);
      check_outs("acc_new0", 2'd0, 1'b1, 4'b0001, 1'b0);
      step(1'b0, 1'b1, 4'b1000, 1'b1);
      check_outs("acc_new1", 2'd3, 1'b1, 4'b1000, 1'b0);
      step(1'b0, 1'b1, 4'b0000, 1'b1);
      check_outs("acc_new2", 2'd3, 1'b0, 4'b0000, 1'b0);

`ifdef PENDING_ENC_DROP_CNT_EN
      // Saturation: four duplicates per cycle while all lines are pending.
      step(1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b0, 1'b1, 4'b1111, 1'b0);
      check("sat0.DROPS", DROPS, 8'd0);
      step(1'b0, 1'b1, 4'b1111, 1'b0);
      check("sat1.DROPS", DROPS, 8'd4);
      for (int k = 0; k < 70; k++) begin
         step(1'b0, 1'b1, 4'b1111, 1'b0);
      end
      check("sat2.DROPS", DROPS, 8'd255);
      check("sat2.OVF", {7'd0, OVF}, 8'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
